// File: rtl/x1_ioctl_upload.sv
// HPS upload responder for the X1 core: answers ioctl_rd with a byte read from
// RAM, VRAM, PCG or GRAM through each memory's spare dpram port.
module x1_ioctl_upload #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic        mem_rd,
  input  logic [7:0]  mem_q_ram,
  input  logic [7:0]  mem_q_vram,
  input  logic [7:0]  mem_q_pcg,
  input  logic [7:0]  mem_q_gram,
  output logic [24:0] byte_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LAT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  // One-hot region select, all-zero when index or address is out of range.
  function automatic logic [3:0] region_sel(input logic [7:0] idx, input logic [24:0] addr);
    logic [3:0] sel;
    case (idx)
      8'h10:   sel = (addr < 25'h0010000) ? 4'b0001 : 4'b0000;
      8'h11:   sel = (addr < 25'h0001000) ? 4'b0010 : 4'b0000;
      8'h12:   sel = (addr < 25'h0001800) ? 4'b0100 : 4'b0000;
      8'h13:   sel = (addr < 25'h000C000) ? 4'b1000 : 4'b0000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [7:0] q_mux(input logic [3:0] sel, input logic [7:0] q_ram,
                                       input logic [7:0] q_vram, input logic [7:0] q_pcg,
                                       input logic [7:0] q_gram);
    logic [7:0] q;
    case (sel)
      4'b0001: q = q_ram;
      4'b0010: q = q_vram;
      4'b0100: q = q_pcg;
      4'b1000: q = q_gram;
      default: q = 8'hFF;
    endcase
    return q;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic        rd_q, rd_d;
  logic [24:0] count_q, count_d;
  logic        inv_q, inv_d;
  logic        upload_q;

  logic [3:0]  req_sel_s;
  logic        req_valid_s;
  logic        accept_s;
  logic        abort_s;
  logic        upload_rise_s;

  assign req_sel_s     = region_sel(ioctl_index, ioctl_addr);
  assign req_valid_s   = |req_sel_s;
  assign accept_s      = (state_q == S_IDLE) && ioctl_rd && ioctl_upload;
  assign abort_s       = (state_q != S_IDLE) && !ioctl_upload;
  assign upload_rise_s = ioctl_upload && !upload_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      din_q    <= 8'hFF;
      wait_q   <= 1'b0;
      addr_q   <= 16'h0000;
      sel_q    <= 4'b0000;
      rd_q     <= 1'b0;
      count_q  <= 25'd0;
      inv_q    <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      inv_q    <= inv_d;
      upload_q <= ioctl_upload;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = accept_s ? (req_valid_s ? S_ISSUE : S_DONE) : S_IDLE;
        S_ISSUE: state_d = S_LAT;
        S_LAT:   state_d = (cnt_q == 2'd0) ? S_DONE : S_LAT;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Completion (data capture, wait drop, count) lands on the edge where wait falls:
  // LAT->DONE for a memory read, DONE->IDLE for a rejected request.
  always_comb begin
    cnt_d   = cnt_q;
    din_d   = din_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    rd_d    = 1'b0;
    count_d = count_q;
    inv_d   = inv_q;
    if (abort_s) begin
      wait_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            wait_d = 1'b1;
            inv_d  = !req_valid_s;
            rd_d   = req_valid_s;
            addr_d = req_valid_s ? ioctl_addr[15:0] : addr_q;
            sel_d  = req_valid_s ? req_sel_s : sel_q;
          end else begin
            wait_d = 1'b0;
          end
        end
        S_ISSUE: cnt_d = LAT_INIT;
        S_LAT: begin
          if (cnt_q == 2'd0) begin
            din_d   = q_mux(sel_q, mem_q_ram, mem_q_vram, mem_q_pcg, mem_q_gram);
            wait_d  = 1'b0;
            count_d = count_q + 25'd1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        S_DONE: begin
          if (inv_q) begin
            din_d   = 8'hFF;
            wait_d  = 1'b0;
            count_d = count_q + 25'd1;
            inv_d   = 1'b0;
          end else begin
            wait_d = 1'b0;
          end
        end
        default: wait_d = 1'b0;
      endcase
    end
    if (upload_rise_s) begin
      count_d = 25'd0;
    end else begin
      count_d = count_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_addr   = addr_q;
  assign mem_sel    = sel_q;
  assign mem_rd     = rd_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_x1_ioctl_upload.sv
// Directed bench for x1_ioctl_upload: one instance with RD_LAT=1 (index 0) and one
// with RD_LAT=3 (index 1), each fed by a behavioural memory of matching latency.
module tb_x1_ioctl_upload;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic [1:0]        reset_n, upload, rd, wt, mrd;
  logic [1:0][7:0]   idx, din, qr, qv, qp, qg;
  logic [1:0][24:0]  addr, bc;
  logic [1:0][15:0]  maddr;
  logic [1:0][3:0]   msel;
  logic [1:0][2:0][16:0] pipe;
  logic [1:0][16:0]  tap;

  logic [7:0] ram  [65536];
  logic [7:0] vram [4096];
  logic [7:0] pcg  [6144];
  logic [7:0] gram [49152];

  int n_cmp = 0;
  int n_bad = 0;

  x1_ioctl_upload #(.RD_LAT(1)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n[0]), .ioctl_upload(upload[0]),
    .ioctl_index(idx[0]), .ioctl_rd(rd[0]), .ioctl_addr(addr[0]),
    .ioctl_din(din[0]), .ioctl_wait(wt[0]), .mem_addr(maddr[0]), .mem_sel(msel[0]),
    .mem_rd(mrd[0]), .mem_q_ram(qr[0]), .mem_q_vram(qv[0]), .mem_q_pcg(qp[0]),
    .mem_q_gram(qg[0]), .byte_count(bc[0])
  );

  x1_ioctl_upload #(.RD_LAT(3)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n[1]), .ioctl_upload(upload[1]),
    .ioctl_index(idx[1]), .ioctl_rd(rd[1]), .ioctl_addr(addr[1]),
    .ioctl_din(din[1]), .ioctl_wait(wt[1]), .mem_addr(maddr[1]), .mem_sel(msel[1]),
    .mem_rd(mrd[1]), .mem_q_ram(qr[1]), .mem_q_vram(qv[1]), .mem_q_pcg(qp[1]),
    .mem_q_gram(qg[1]), .byte_count(bc[1])
  );

  // Memory model: data appears exactly RD_LAT cycles after mem_rd, 0xEE otherwise.
  always @(posedge clk_sys) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= {mrd[d], maddr[d]};
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  function automatic logic [7:0] look(input int m, input logic [15:0] a);
    case (m)
      0:       return ram[a];
      1:       return (a < 16'h1000) ? vram[a[11:0]] : 8'h11;
      2:       return (a < 16'h1800) ? pcg[a[12:0]] : 8'h22;
      default: return (a < 16'hC000) ? gram[a] : 8'h33;
    endcase
  endfunction

  always_comb begin
    tap[0] = pipe[0][0];
    tap[1] = pipe[1][2];
    for (int d = 0; d < 2; d++) begin
      qr[d] = tap[d][16] ? look(0, tap[d][15:0]) : 8'hEE;
      qv[d] = tap[d][16] ? look(1, tap[d][15:0]) : 8'hEE;
      qp[d] = tap[d][16] ? look(2, tap[d][15:0]) : 8'hEE;
      qg[d] = tap[d][16] ? look(3, tap[d][15:0]) : 8'hEE;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request on instance d; cycle k is sampled at the k-th falling edge.
  task automatic request(input int d, input logic [7:0] ix, input logic [24:0] a,
                         input bit busy_poke, output int fall, output int nrd,
                         output logic [15:0] ra, output logic [3:0] rs, output logic w1,
                         output logic [7:0] fdin, output logic [24:0] fbc);
    fall = 0; nrd = 0; ra = 16'h0000; rs = 4'b0000; w1 = 1'b0; fdin = 8'h00; fbc = 25'd0;
    idx[d] = ix; addr[d] = a; rd[d] = 1'b1;
    for (int k = 1; k <= 12 && fall == 0; k++) begin
      @(negedge clk_sys);
      if (k == 1) begin
        w1 = wt[d];
        rd[d] = busy_poke;
        addr[d] = busy_poke ? 25'h0000FFF : a;
      end else begin
        rd[d] = 1'b0;
      end
      if (mrd[d]) begin
        nrd++; ra = maddr[d]; rs = msel[d];
      end
      if (!wt[d]) begin
        fall = k; fdin = din[d]; fbc = bc[d];
      end
    end
    if (fall == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got wait stuck high, want fall within 12 cycles");
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_sys);
      if (mrd[d]) nrd++;
    end
  endtask

  typedef struct {
    int          dut;
    logic [7:0]  ix;
    logic [24:0] a;
    bit          ok;
    logic [7:0]  exp;
    logic [3:0]  sel;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    int fall, nrd, lat;
    logic [15:0] ra;
    logic [3:0] rs, sel0;
    logic w1;
    logic [7:0] fdin, din0;
    logic [24:0] fbc, bc0;

    vecs[0] = '{0, 8'h10, 25'h0001234, 1'b1, 8'hA5, 4'b0001};
    vecs[1] = '{0, 8'h12, 25'h00017FF, 1'b1, 8'h9D, 4'b0100};
    vecs[2] = '{0, 8'h12, 25'h0001800, 1'b0, 8'hFF, 4'b0000};
    vecs[3] = '{0, 8'h13, 25'h000C000, 1'b0, 8'hFF, 4'b0000};
    vecs[4] = '{0, 8'h20, 25'h0000000, 1'b0, 8'hFF, 4'b0000};
    vecs[5] = '{1, 8'h11, 25'h0000FFF, 1'b1, 8'h3C, 4'b0010};
    vecs[6] = '{1, 8'h13, 25'h000BFFF, 1'b1, 8'h7E, 4'b1000};
    vecs[7] = '{0, 8'h10, 25'h000FFFF, 1'b1, 8'h81, 4'b0001};
    vecs[8] = '{0, 8'h10, 25'h0010000, 1'b0, 8'hFF, 4'b0000};
    vecs[9] = '{1, 8'h11, 25'h0001000, 1'b0, 8'hFF, 4'b0000};

    ram[16'h1234] = 8'hA5; pcg[13'h1234] = 8'h5B; gram[16'h1234] = 8'h6C;
    ram[16'h17FF] = 8'h01; pcg[13'h17FF] = 8'h9D; gram[16'h17FF] = 8'h02;
    ram[16'h0FFF] = 8'h03; vram[12'hFFF] = 8'h3C; pcg[13'h0FFF] = 8'h04; gram[16'h0FFF] = 8'h05;
    ram[16'hBFFF] = 8'h06; gram[16'hBFFF] = 8'h7E;
    ram[16'hFFFF] = 8'h81;

    reset_n = 2'b00; upload = 2'b00; rd = 2'b00; idx = '0; addr = '0;
    repeat (3) @(negedge clk_sys);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_din", d), din[d], 8'hFF);
      chk($sformatf("rst%0d_wait", d), wt[d], 1'b0);
      chk($sformatf("rst%0d_mem_addr", d), maddr[d], 16'h0000);
      chk($sformatf("rst%0d_mem_sel", d), msel[d], 4'b0000);
      chk($sformatf("rst%0d_mem_rd", d), mrd[d], 1'b0);
      chk($sformatf("rst%0d_byte_count", d), bc[d], 25'd0);
    end
    reset_n = 2'b11; upload = 2'b11;
    repeat (2) @(negedge clk_sys);

    for (int i = 0; i < 10; i++) begin
      lat  = (vecs[i].dut == 0) ? 1 : 3;
      bc0  = bc[vecs[i].dut];
      sel0 = msel[vecs[i].dut];
      request(vecs[i].dut, vecs[i].ix, vecs[i].a, 1'b0, fall, nrd, ra, rs, w1, fdin, fbc);
      chk($sformatf("v%0d_wait_c1", i), w1, 1'b1);
      chk($sformatf("v%0d_fall_cycle", i), fall, vecs[i].ok ? 2 + lat : 2);
      chk($sformatf("v%0d_din", i), fdin, vecs[i].exp);
      chk($sformatf("v%0d_mem_rd_count", i), nrd, vecs[i].ok ? 1 : 0);
      chk($sformatf("v%0d_byte_count", i), fbc, bc0 + 25'd1);
      if (vecs[i].ok) begin
        chk($sformatf("v%0d_mem_sel", i), rs, vecs[i].sel);
        chk($sformatf("v%0d_mem_addr", i), ra, vecs[i].a[15:0]);
      end else begin
        chk($sformatf("v%0d_mem_sel_hold", i), msel[vecs[i].dut], sel0);
      end
    end

    // Second ioctl_rd while busy is dropped.
    bc0 = bc[0];
    request(0, 8'h10, 25'h0001234, 1'b1, fall, nrd, ra, rs, w1, fdin, fbc);
    chk("busy_din", fdin, 8'hA5);
    chk("busy_mem_rd_count", nrd, 1);
    chk("busy_mem_addr", ra, 16'h1234);
    chk("busy_byte_count", fbc, bc0 + 25'd1);

    // ioctl_rd during the DONE cycle is ignored.
    idx[0] = 8'h10; addr[0] = 25'h0000FFF; rd[0] = 1'b1;
    @(negedge clk_sys); rd[0] = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("done_c3_wait", wt[0], 1'b0);
    chk("done_c3_din", din[0], 8'h03);
    idx[0] = 8'h11; addr[0] = 25'h0000000; rd[0] = 1'b1;
    @(negedge clk_sys); rd[0] = 1'b0;
    chk("done_rd_wait", wt[0], 1'b0);
    chk("done_rd_mem_rd", mrd[0], 1'b0);
    @(negedge clk_sys);
    chk("done_rd_mem_rd_c5", mrd[0], 1'b0);
    chk("done_rd_din", din[0], 8'h03);

    // Abort on the RD_LAT=3 instance by dropping ioctl_upload at cycle 2.
    din0 = din[1]; bc0 = bc[1];
    idx[1] = 8'h10; addr[1] = 25'h0001234; rd[1] = 1'b1;
    @(negedge clk_sys); rd[1] = 1'b0;
    @(negedge clk_sys); upload[1] = 1'b0;
    @(negedge clk_sys);
    chk("abort_wait", wt[1], 1'b0);
    chk("abort_din", din[1], din0);
    chk("abort_byte_count", bc[1], bc0);
    nrd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      if (mrd[1]) nrd++;
    end
    chk("abort_mem_rd_count", nrd, 0);
    chk("abort_din_late", din[1], din0);
    idx[1] = 8'h10; addr[1] = 25'h0000000; rd[1] = 1'b1;
    @(negedge clk_sys); rd[1] = 1'b0;
    chk("no_upload_wait", wt[1], 1'b0);
    @(negedge clk_sys);
    chk("no_upload_mem_rd", mrd[1], 1'b0);
    chk("no_upload_byte_count", bc[1], bc0);
    upload[1] = 1'b1;
    @(negedge clk_sys);
    chk("upload_rise_clear", bc[1], 25'd0);

    // Reset in the middle of a request.
    idx[0] = 8'h10; addr[0] = 25'h0001234; rd[0] = 1'b1;
    @(negedge clk_sys); rd[0] = 1'b0; reset_n[0] = 1'b0;
    @(negedge clk_sys);
    chk("midrst_wait", wt[0], 1'b0);
    chk("midrst_mem_rd", mrd[0], 1'b0);
    chk("midrst_din", din[0], 8'hFF);
    chk("midrst_byte_count", bc[0], 25'd0);
    chk("midrst_mem_sel", msel[0], 4'b0000);
    reset_n[0] = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/x1_ioctl_upload.md
# x1_ioctl_upload

Responder for the HPS upload direction of the ioctl interface: serves `ioctl_rd` requests by reading bytes out of the X1 memories (main RAM, VRAM, PCG RAM, GRAM) and returning them on `ioctl_din`. It stretches each request with `ioctl_wait` until the data is valid. It sits beside the download path in the X1 top level and drives the spare port of each memory's dpram. Used for memory dumps and state save.

## Interface
- `RD_LAT`, default 1: memory read latency in clk_sys cycles from `mem_rd` to valid `mem_q_*`; legal 1..3.
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ioctl_upload` in 1: upload session active (level).
- `ioctl_index` in 8: region select, sampled with each `ioctl_rd`.
- `ioctl_rd` in 1: single-cycle read request strobe.
- `ioctl_addr` in 25: byte address within the region, sampled with `ioctl_rd`.
- `ioctl_din` out 8: returned byte (registered).
- `ioctl_wait` out 1: high while a request is in flight.
- `mem_addr` out 16: address to the selected memory port.
- `mem_sel` out 4: one-hot select; bit0 RAM, bit1 VRAM, bit2 PCG, bit3 GRAM.
- `mem_rd` out 1: one-cycle read strobe.
- `mem_q_ram`, `mem_q_vram`, `mem_q_pcg`, `mem_q_gram` in 8 each: memory read data.
- `byte_count` out 25: completed reads in the current session.

## Operation
- Region map: index 0x10 is RAM, valid addr < 0x10000. Index 0x11 is VRAM, < 0x1000. Index 0x12 is PCG, < 0x1800. Index 0x13 is GRAM, < 0xC000.
- Any other index, or an address at or above the region limit, is an invalid request. It returns 0xFF with no `mem_rd` and no change to `mem_sel`.
- FSM states: IDLE, ISSUE, LAT, DONE.
- IDLE:
  - A request is accepted when `ioctl_rd`=1 and `ioctl_upload`=1.
  - On acceptance: latch index and addr, decode, set `ioctl_wait`=1.
  - Valid request goes to ISSUE. Invalid request goes to DONE, with 0xFF staged as the result.
- ISSUE: `mem_rd`=1 for exactly one cycle. `mem_addr` is the latched addr[15:0]; `mem_sel` is the decoded one-hot. Go to LAT and load the latency counter with RAM latency minus 1.
- LAT:
  - Count down.
  - At zero, capture the `mem_q_*` selected by `mem_sel` into `ioctl_din` and go to DONE.
  - With RD_LAT=1 the capture happens on the first LAT cycle.
- DONE: `ioctl_wait`=0, `byte_count` += 1, go to IDLE.
- `mem_addr` and `mem_sel` hold their last value outside ISSUE. The memory side only uses them under `mem_rd`.
- `ioctl_rd` while not in IDLE is ignored. No queueing, no side effect.
- `ioctl_rd` with `ioctl_upload`=0 is ignored.
- `ioctl_upload` rising edge clears `byte_count` to 0.
- `ioctl_upload` falling while busy aborts:
  - Next state is IDLE; `ioctl_wait`=0 next cycle.
  - `ioctl_din` and `byte_count` are unchanged; `mem_rd` is not asserted after the abort.
- `byte_count` wraps at 2^25 (not reachable in practice).

## Timing
- Reset values: `ioctl_din`=0xFF, `ioctl_wait`=0, `mem_addr`=0, `mem_sel`=0, `mem_rd`=0, `byte_count`=0, FSM=IDLE.
- `reset_n` low mid-request returns everything to reset values on the next edge.
- Cycle numbering for a valid request, with `ioctl_rd` sampled high at cycle 0:
  - Cycle 1: `ioctl_wait`=1 and `mem_rd`=1 (ISSUE).
  - Cycle 1+RD_LAT: `mem_q` is sampled into `ioctl_din`.
  - Cycle 2+RD_LAT: `ioctl_din` is valid and `ioctl_wait`=0.
  - Total turnaround is 2+RD_LAT cycles; with RD_LAT=1 that is 3.
- Invalid request: `ioctl_wait` high during cycle 1; `ioctl_din`=0xFF and `ioctl_wait`=0 at cycle 2.
- `ioctl_din` is stable from the `ioctl_wait` falling edge until the next capture.
- Maximum throughput is one byte per 3+RD_LAT cycles, because a new `ioctl_rd` is only accepted from the cycle after DONE.
- `ioctl_rd` in the same cycle that DONE completes is ignored.

## Test plan
- Valid RAM read:
  - Stimulus: RD_LAT=1, RAM[0x1234]=0xA5, `ioctl_upload`=1, index 0x10, addr 0x1234, `ioctl_rd` pulse.
  - Required: `mem_rd` at cycle 1 with `mem_sel`=0001 and `mem_addr`=0x1234; `ioctl_din`=0xA5 with `ioctl_wait`=0 at cycle 3; `byte_count`=1.
- Region limits:
  - Stimulus: PCG addr 0x17FF, then 0x1800; GRAM addr 0xC000; index 0x20.
  - Required: 0x17FF returns memory data. The other three return 0xFF at cycle 2 with no `mem_rd`.
- Latency parameter: RD_LAT=3, VRAM read of addr 0x0FFF holding 0x3C → `ioctl_din`=0x3C, `ioctl_wait` falls at cycle 5.
- Busy ignore: second `ioctl_rd` at cycle 1 with a different addr → only one `mem_rd`, first address's data returned, `byte_count` +1.
- Abort:
  - Stimulus: RD_LAT=3, drop `ioctl_upload` at cycle 2.
  - Required: `ioctl_wait`=0 at cycle 3, `ioctl_din` unchanged, `byte_count` unchanged. Re-raising `ioctl_upload` clears `byte_count`.
- Reset mid-request: `reset_n`=0 at cycle 1 → next edge `ioctl_wait`=0, `mem_rd`=0, `ioctl_din`=0xFF, `byte_count`=0.
